mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM (IF/ID/EX/MEM/WB) for a small MIPS-like subset.
// Optional feature: define MC_CU_PERF_EN to add cycle_cnt / instr_cnt performance counters.
module mc_control_unit #(
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic              rsrtequ,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              pcwrite,
    output logic              irwrite,
    output logic              wreg,
    output logic              wmem,
    output logic              m2reg,
    output logic              regrt,
    output logic              aluimm,
    output logic              sext,
    output logic [ALUC_W-1:0] aluc,
    output logic [1:0]        pcsource,
    output logic [2:0]        state,
    output logic              illegal
`ifdef MC_CU_PERF_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
`endif
);
    localparam logic [5:0] OP_R    = 6'b000001;
    localparam logic [5:0] OP_ORI  = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001101;
    localparam logic [5:0] OP_SW   = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b010010;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t st, nx;
    logic is_r, is_ori, is_addi, is_lw, is_sw, is_beq, is_j, legal;
    logic [ALUC_W-1:0] dec_aluc;
    logic unused_bits;

    assign is_r     = op == OP_R;
    assign is_ori   = op == OP_ORI;
    assign is_addi  = op == OP_ADDI;
    assign is_lw    = op == OP_LW;
    assign is_sw    = op == OP_SW;
    assign is_beq   = op == OP_BEQ;
    assign is_j     = op == OP_J;
    assign legal    = is_r | is_ori | is_addi | is_lw | is_sw | is_beq | is_j;
    assign dec_aluc = is_r ? ALUC_W'(func[2:0]) : is_ori ? ALUC_W'(3) : is_beq ? ALUC_W'(1) : '0;
    assign state    = st;
    // only func[2:0] selects the ALU operation; the upper bits are don't-care
    assign unused_bits = ^{func[5:3], CNT_W > 0};

    // next-state selection; ready strobes only matter in their own wait state
    always_comb begin
        case (st)
            S_IF:    nx = imem_ready ? S_ID : S_IF;
            S_ID:    nx = (is_j || !legal) ? S_IF : S_EX;
            S_EX:    nx = is_beq ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:   nx = dmem_ready ? (is_lw ? S_WB : S_IF) : S_MEM;
            S_WB:    nx = S_IF;
            default: nx = S_IF;
        endcase
    end

    // state register; reset parks the machine in IF at once
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) st <= S_IF;
        else       st <= nx;
    end

    // strobes and selects from state and instruction fields, all forced low during reset
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        pcwrite  = 1'b0;
        irwrite  = 1'b0;
        wreg     = 1'b0;
        wmem     = 1'b0;
        m2reg    = 1'b0;
        regrt    = 1'b0;
        aluimm   = 1'b0;
        sext     = 1'b0;
        illegal  = 1'b0;
        aluc     = '0;
        pcsource = 2'b00;
        if (clrn) begin
            imem_req = st == S_IF;
            irwrite  = st == S_IF && imem_ready;
            pcwrite  = (st == S_IF && imem_ready) || (st == S_ID && is_j) || (st == S_EX && is_beq && rsrtequ);
            pcsource = (st == S_ID && is_j) ? 2'b11 : (st == S_EX && is_beq) ? 2'b01 : 2'b00;
            illegal  = st == S_ID && !legal;
            dmem_req = st == S_MEM;
            wmem     = st == S_MEM && is_sw;
            wreg     = st == S_WB;
            if (st != S_IF) begin
                aluc   = dec_aluc;
                aluimm = is_ori | is_addi | is_lw | is_sw;
                sext   = is_addi | is_lw | is_sw | is_beq;
                regrt  = is_ori | is_addi | is_lw;
                m2reg  = is_lw;
            end
        end
    end

`ifdef MC_CU_PERF_EN
    // free-running cycle counter and fetched-instruction counter, both wrapping
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (st == S_IF && imem_ready) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif
endmodule
